mc_control_unit: RTL and testbench
==================================

// Module: mc_control_unit
// PURPOSE
//  Multicycle CPU control FSM; drives the selects of the datapath muxes
//  (including the 2-bit ALU-B select) and every register/memory write strobe.
//  Decodes opcode/funct from IR, sequences fetch/decode/execute/mem/writeback,
//  and stretches memory phases by a configurable wait count.
// PARAMETERS
//  MEM_WAIT  1  cycles from memory address-valid to data-valid (>=1)
//  CNT_W     3  width of wait counter; must hold MEM_WAIT
// PORTS
//  clk          in   1  system clock, all state updates on rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  alu_src_a    out  1  0=PC, 1=A register
//  alu_src_b    out  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_ctrl     out  3  001 add, 010 sub, 011 and, 100 or, 111 slt, 000 idle
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  pc_write     out  1  PC load strobe
//  i_or_d       out  1  memory address: 0=PC, 1=ALUOut
//  mem_wr       out  1  memory write strobe
//  ir_write / mdr_write / ab_write / alu_out_write  out 1 each: register load strobes
//  reg_write    out  1  register-file write strobe
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  exception    out  1  sticky: unsupported opcode/funct seen
// BEHAVIOUR
//  Reset: state<=FETCH, wait_cnt<=0, exception<=0. Outputs are combinational from
//   state; while reset=1 all strobes and selects are 0. Reset mid-instruction aborts
//   it, with no strobe in the reset cycle.
//  Unlisted outputs are 0 in each state. "last" means wait_cnt==MEM_WAIT-1; the
//   counter increments in FETCH/MEM_READ and clears on leaving them.
//  FETCH: i_or_d=0, src_a=0, src_b=01, add. On last: ir_write=1, pc_write=1,
//   pc_src=00, then ->DECODE. Otherwise stay.
//  DECODE: ab_write=1, src_a=0, src_b=11, add, alu_out_write=1 (branch target).
//   Dispatch on opcode: 000000->R_EXEC (invalid funct->EXCEPT), 001000->ADDI_EXEC,
//   100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, else->EXCEPT.
//  R_EXEC: src_a=1, src_b=00, alu_ctrl by funct (100000 add, 100010 sub, 100100 and,
//   100101 or, 101010 slt), alu_out_write=1 ->R_WB.
//  R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 ->FETCH.
//  ADDI_EXEC: src_a=1, src_b=10, add, alu_out_write=1 ->ADDI_WB.
//  ADDI_WB: reg_dst=0, reg_write=1 ->FETCH.
//  MEM_ADDR: src_a=1, src_b=10, add, alu_out_write=1. Lw->MEM_READ, sw->MEM_WRITE
//   (opcode held stable by IR).
//  MEM_READ: i_or_d=1. On last: mdr_write=1 ->MEM_WB.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 ->FETCH.
//  MEM_WRITE: i_or_d=1, mem_wr=1 for exactly one cycle ->FETCH.
//  BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_write=zero ->FETCH.
//  JUMP: pc_src=10, pc_write=1 ->FETCH.
//  EXCEPT: exception<=1. Terminal: all strobes 0 until reset.
//  Never two write strobes to the same register in one cycle.
//   pc_write is never 1 outside FETCH-last, BRANCH or JUMP.
//  Instruction cycle counts (MEM_WAIT=W):
//   R/addi = W+3, lw = 2W+3, sw = W+3, beq/j = W+2.
// TESTING
//  W=1, add (op 0, funct 20h) -> FETCH,DECODE,R_EXEC,R_WB in 4 cycles;
//   src_b 01,11,00,x; reg_write only in cycle 4 with reg_dst=1.
//  W=3, lw (op 23h) -> 9 cycles; ir_write on cycle 3; mdr_write on cycle 8;
//   reg_write+mem_to_reg=1 on cycle 9.
//  beq with zero=1 -> pc_write=1, pc_src=01 in BRANCH. With zero=0 -> no
//   pc_write after FETCH.
//  sw (op 2Bh) -> mem_wr=1 for exactly 1 cycle, i_or_d=1, reg_write never set.
//  op 3Fh, or R-type funct 3Fh -> EXCEPT, exception=1 stays high, no strobes
//   over 20 cycles; reset -> exception=0, FETCH.
//  reset asserted during MEM_READ -> strobes 0 that cycle, FETCH next,
//   wait_cnt=0, no mdr_write.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing,
// datapath mux selects and register/memory write strobes, with stretched memory phases.
module mc_control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exception
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_R_EXEC,
    S_R_WB,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_BRANCH,
    S_JUMP,
    S_EXCEPT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             exception_q, exception_d;

  logic             last;
  logic             funct_ok;
  logic [2:0]       r_alu;

  assign last = (wait_cnt_q == CNT_LAST);

  // R-type funct decode; funct_ok also gates dispatch out of DECODE.
  always_comb begin
    funct_ok = 1'b1;
    r_alu    = ALU_IDLE;
    case (funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      exception_q <= exception_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    exception_d   = exception_q;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_IDLE;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        if (last) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut while A/B load.
        ab_write      = 1'b1;
        alu_src_b     = 2'b11;
        alu_ctrl      = ALU_ADD;
        alu_out_write = 1'b1;
        case (opcode)
          OP_RTYPE:      state_d = funct_ok ? S_R_EXEC : S_EXCEPT;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_EXCEPT;
        endcase
      end
      S_R_EXEC: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = r_alu;
        alu_out_write = 1'b1;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_ctrl      = ALU_ADD;
        alu_out_write = 1'b1;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b10;
        alu_ctrl      = ALU_ADD;
        alu_out_write = 1'b1;
        state_d       = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        i_or_d = 1'b1;
        if (last) begin
          mdr_write = 1'b1;
          state_d   = S_MEM_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d  = 1'b1;
        mem_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXCEPT: begin
        exception_d = 1'b1;
      end
      default: begin
        state_d = S_EXCEPT;
      end
    endcase

    // An aborted instruction must not leak any strobe in the reset cycle.
    if (reset) begin
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = ALU_IDLE;
      pc_src        = 2'b00;
      pc_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_wr        = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      ab_write      = 1'b0;
      alu_out_write = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
    end
  end

  assign exception = exception_q & ~reset;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: two instances (MEM_WAIT=1 and 3) checked cycle by cycle
// against per-instruction expected control sequences built from the instruction rules.
module tb_mc_control_unit;

  typedef struct packed {
    logic       exc;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic [1:0] pc_src;
    logic       pc_wr;
    logic       i_or_d;
    logic       mem_wr;
    logic       ir_wr;
    logic       mdr_wr;
    logic       ab_wr;
    logic       aluout_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       m2r;
  } ctl_t;

  localparam logic [5:0] FN_LIST [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  localparam logic [5:0] OP_LIST [6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};

  logic       clk = 1'b0;
  logic       rst  [2];
  logic [5:0] op   [2];
  logic [5:0] fn   [2];
  logic       zr   [2];
  ctl_t       obs  [2];
  ctl_t       exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       a_src_a, a_pc_wr, a_iord, a_memwr, a_irwr, a_mdrwr, a_abwr;
    logic       a_aowr, a_regwr, a_regdst, a_m2r, a_exc;
    logic [1:0] a_src_b, a_pc_src;
    logic [2:0] a_alu;

    mc_control_unit #(.MEM_WAIT(g == 0 ? 1 : 3), .CNT_W(3)) dut (
      .clk          (clk),
      .reset        (rst[g]),
      .opcode       (op[g]),
      .funct        (fn[g]),
      .zero         (zr[g]),
      .alu_src_a    (a_src_a),
      .alu_src_b    (a_src_b),
      .alu_ctrl     (a_alu),
      .pc_src       (a_pc_src),
      .pc_write     (a_pc_wr),
      .i_or_d       (a_iord),
      .mem_wr       (a_memwr),
      .ir_write     (a_irwr),
      .mdr_write    (a_mdrwr),
      .ab_write     (a_abwr),
      .alu_out_write(a_aowr),
      .reg_write    (a_regwr),
      .reg_dst      (a_regdst),
      .mem_to_reg   (a_m2r),
      .exception    (a_exc)
    );

    assign obs[g] = {a_exc, a_src_a, a_src_b, a_alu, a_pc_src, a_pc_wr, a_iord, a_memwr,
                     a_irwr, a_mdrwr, a_abwr, a_aowr, a_regwr, a_regdst, a_m2r};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b001;
      6'h22:   return 3'b010;
      6'h24:   return 3'b011;
      6'h25:   return 3'b100;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Expected per-cycle controls for one whole instruction, starting at its first FETCH cycle.
  task automatic gen(input logic [5:0] o, input logic [5:0] f, input logic z, input int w);
    ctl_t c;
    exp_q.delete();
    for (int i = 0; i < w; i++) begin
      c = '0; c.src_b = 2'b01; c.alu = 3'b001;
      if (i == w - 1) begin c.ir_wr = 1'b1; c.pc_wr = 1'b1; end
      exp_q.push_back(c);
    end
    c = '0; c.ab_wr = 1'b1; c.src_b = 2'b11; c.alu = 3'b001; c.aluout_wr = 1'b1;
    exp_q.push_back(c);
    if (o == 6'h00 && alu_of(f) != 3'b000) begin
      c = '0; c.src_a = 1'b1; c.alu = alu_of(f); c.aluout_wr = 1'b1; exp_q.push_back(c);
      c = '0; c.reg_dst = 1'b1; c.reg_wr = 1'b1; exp_q.push_back(c);
    end else if (o == 6'h08) begin
      c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 3'b001; c.aluout_wr = 1'b1;
      exp_q.push_back(c);
      c = '0; c.reg_wr = 1'b1; exp_q.push_back(c);
    end else if (o == 6'h23 || o == 6'h2B) begin
      c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu = 3'b001; c.aluout_wr = 1'b1;
      exp_q.push_back(c);
      if (o == 6'h23) begin
        for (int i = 0; i < w; i++) begin
          c = '0; c.i_or_d = 1'b1; c.mdr_wr = (i == w - 1); exp_q.push_back(c);
        end
        c = '0; c.reg_wr = 1'b1; c.m2r = 1'b1; exp_q.push_back(c);
      end else begin
        c = '0; c.i_or_d = 1'b1; c.mem_wr = 1'b1; exp_q.push_back(c);
      end
    end else if (o == 6'h04) begin
      c = '0; c.src_a = 1'b1; c.alu = 3'b010; c.pc_src = 2'b01; c.pc_wr = z; exp_q.push_back(c);
    end else if (o == 6'h02) begin
      c = '0; c.pc_src = 2'b10; c.pc_wr = 1'b1; exp_q.push_back(c);
    end else begin
      // Terminal: silent, flag registered one cycle after entry and held.
      for (int i = 0; i < 20; i++) begin
        c = '0; c.exc = (i > 0); exp_q.push_back(c);
      end
    end
  endtask

  // Tasks start and end just after a rising edge; checks happen on the falling edge.
  task automatic cycle(input int d, input ctl_t e, input string tag);
    @(negedge clk);
    check(tag, {12'b0, obs[d]}, {12'b0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d, input string name);
    rst[d] = 1'b1;
    @(negedge clk);
    check($sformatf("%s_rst d%0d", name, d), {12'b0, obs[d]}, 32'h0);
    @(posedge clk);
    #1;
    rst[d] = 1'b0;
  endtask

  task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input string name);
    int w = (d == 0) ? 1 : 3;
    op[d] = o; fn[d] = f; zr[d] = z;
    gen(o, f, z, w);
    for (int i = 0; i < exp_q.size(); i++)
      cycle(d, exp_q[i], $sformatf("%s d%0d c%0d", name, d, i + 1));
  endtask

  task automatic reset_in_read(input int d);
    int w = (d == 0) ? 1 : 3;
    int n = w + 2 + ((w > 1) ? 1 : 0);
    op[d] = 6'h23; fn[d] = 6'h00; zr[d] = 1'b0;
    gen(6'h23, 6'h00, 1'b0, w);
    for (int i = 0; i < n; i++)
      cycle(d, exp_q[i], $sformatf("lw_abort d%0d c%0d", d, i + 1));
    do_reset(d, "midread");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; op[d] = '0; fn[d] = '0; zr[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      do_reset(d, "init");
      run_instr(d, 6'h00, 6'h20, 1'b0, "add");
      run_instr(d, 6'h23, 6'h11, 1'b0, "lw");
      run_instr(d, 6'h04, 6'h00, 1'b1, "beq_t");
      run_instr(d, 6'h04, 6'h00, 1'b0, "beq_nt");
      run_instr(d, 6'h2B, 6'h07, 1'b1, "sw");
      run_instr(d, 6'h08, 6'h3F, 1'b0, "addi");
      run_instr(d, 6'h02, 6'h01, 1'b1, "j");
      for (int k = 0; k < 40; k++) begin
        logic [5:0] o, f;
        o = OP_LIST[$urandom_range(0, 5)];
        f = (o == 6'h00) ? FN_LIST[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
        run_instr(d, o, f, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      end
      reset_in_read(d);
      run_instr(d, 6'h00, 6'h22, 1'b0, "after_abort");
      run_instr(d, 6'h3F, 6'h20, 1'b0, "bad_op");
      do_reset(d, "exc_clr");
      run_instr(d, 6'h00, 6'h3F, 1'b0, "bad_fn");
      do_reset(d, "exc_clr2");
      run_instr(d, 6'h00, 6'h2A, 1'b1, "slt");
      rst[d] = 1'b1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
